uart_rx_fifo: RTL
=================

# uart_rx_fifo

Byte buffer that sits directly downstream of the UART character receiver. It captures each received byte on the receiver's one-cycle finished strobe and stores it in a first-word-fall-through FIFO. It presents the bytes to the command and host logic, and flags bytes lost to overflow. An optional counter tracks how many complete lines (LF-terminated) are buffered.

## Interface
- DEPTH, 16, number of byte entries; power of two, 4..256.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

- i_clk  in  1  system clock, 23.04 MHz.
- i_rst  in  1  asynchronous, active-low reset.
- i_char  in  8  received byte from the receiver.
- i_valid  in  1  one-cycle strobe: i_char is valid (receiver finished pulse).
- i_rd  in  1  pop head entry this cycle.
- i_clr_ovf  in  1  clear sticky overflow flag.
- o_data  out  8  head entry (FWFT); 8'h00 when empty.
- o_empty  out  1  FIFO holds no entries.
- o_full  out  1  FIFO holds DEPTH entries.
- o_count  out  AW+1  number of stored entries, 0..DEPTH.
- o_overflow  out  1  sticky: at least one byte dropped.
- o_lines  out  AW+1  number of stored 8'h0A bytes.
- o_line_rdy  out  1  o_lines != 0.

## Operation
- Storage: DEPTH x 8 register array, write pointer wp and read pointer rp (AW bits each, wrap modulo DEPTH), entry counter cnt (AW+1 bits). The array itself is not reset.
- push = i_valid && (!full || i_rd). A push writes i_char to mem[wp], then wp+1.
- pop = i_rd && !empty. A pop advances rp by 1.
- cnt: +1 on push only, -1 on pop only, unchanged on both or neither.
- Empty with i_valid and i_rd in the same cycle: the push is accepted and the pop is ignored. The result is cnt = 1.
- Full with i_valid and i_rd in the same cycle: both are accepted and cnt stays DEPTH.
- Full with i_valid and no i_rd: the byte is dropped, o_overflow is set, and the pointers and cnt are unchanged.
- o_overflow stays set until i_clr_ovf is asserted. If a new drop happens in the same cycle as i_clr_ovf, the set wins.
- i_rd while empty has no effect and is not an error.
- o_data = empty ? 8'h00 : mem[rp], combinational from registered state.
- Line counter (macro enabled only):
  - +1 when a push writes 8'h0A.
  - -1 when a pop removes 8'h0A (o_data == 8'h0A).
  - Unchanged when both or neither happen.
  - It never exceeds cnt.

## Timing
- Reset (i_rst low, asynchronous) sets: wp = rp = 0, cnt = 0, o_empty = 1, o_full = 0, o_count = 0, o_overflow = 0, o_lines = 0, o_line_rdy = 0, o_data = 8'h00.
- Write latency: a push on cycle N makes the byte visible on o_data (if it is the head) and updates o_count, o_empty and o_full from cycle N+1.
- Pop: o_data shows the next entry from cycle N+1. The consumer samples o_data in the same cycle it asserts i_rd.
- Flags are registered or derived from registered cnt. There are no combinational paths from i_valid to any output. i_rd affects only the next-state logic.
- i_valid is a single-cycle strobe. If it is held high for k cycles, that is k pushes.
- Sustained input rate is at most one byte per 100 clocks (230400 baud). Throughput is one push and one pop per cycle.
- Reset asserted mid-operation discards all contents immediately. It applies on the asynchronous edge, with no wait for the clock.

## Configuration
- UART_RX_LINE_CNT_EN defined: the line counter is implemented as described. o_lines and o_line_rdy are live.
- Not defined: the counter logic is removed. o_lines is tied to 0 and o_line_rdy to 0. Ports remain so the instantiation is unchanged.

## Test plan
- Reset, then push 8'h41, 8'h42, 8'h43 on strobes 100 cycles apart -> o_count = 3, o_data = 8'h41. Three pops return 41, 42, 43, then o_empty = 1 and o_data = 8'h00.
- Fill with 16 bytes (DEPTH = 16), then push 8'hFF without i_rd -> o_full = 1, o_overflow = 1, o_count = 16, head unchanged. i_clr_ovf -> o_overflow = 0.
- While full, assert i_valid = 1 (8'h55) and i_rd = 1 together -> o_count stays 16, head advances, 8'h55 becomes the last entry.
- While empty, assert i_valid (8'h10) and i_rd together -> o_count = 1, o_data = 8'h10. Push and pop 40 bytes to exercise pointer wrap with data order preserved.
- With macro defined, push "AB\nC\n" (41 42 0A 43 0A) -> o_lines = 2, o_line_rdy = 1. Pop three bytes -> o_lines = 1. Without macro, o_lines = 0 throughout.
- Assert i_rst low mid-stream with o_count = 5 -> all outputs take reset values immediately. After release, the first push is read back correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with sticky overflow flag.
// Optional LF line counter enabled by `define UART_RX_LINE_CNT_EN.
module uart_rx_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [7:0]    i_char,
   input  logic          i_valid,
   input  logic          i_rd,
   input  logic          i_clr_ovf,
   output logic [7:0]    o_data,
   output logic          o_empty,
   output logic          o_full,
   output logic [AW:0]   o_count,
   output logic          o_overflow,
   output logic [AW:0]   o_lines,
   output logic          o_line_rdy
);

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          empty, full, push, pop, drop;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_FULL);

   // A full FIFO still accepts a byte when the head is leaving in the same cycle.
   assign push = i_valid && (!full || i_rd);
   assign pop  = i_rd && !empty;
   assign drop = i_valid && full && !i_rd;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
      if (drop)           ovf_d = 1'b1;
      else if (i_clr_ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Storage carries no reset; validity comes from cnt.
   always_ff @(posedge i_clk) begin
      if (push) mem_q[wp_q] <= i_char;
   end

   assign o_data     = empty ? 8'h00 : mem_q[rp_q];
   assign o_empty    = empty;
   assign o_full     = full;
   assign o_count    = cnt_q;
   assign o_overflow = ovf_q;

`ifdef UART_RX_LINE_CNT_EN
   logic [AW:0] lines_q, lines_d;
   logic        lf_in, lf_out;

   assign lf_in  = push && (i_char == 8'h0A);
   assign lf_out = pop && (o_data == 8'h0A);

   always_comb begin
      lines_d = lines_q;
      if (lf_in && !lf_out)      lines_d = lines_q + (AW+1)'(1);
      else if (lf_out && !lf_in) lines_d = lines_q - (AW+1)'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) lines_q <= '0;
      else        lines_q <= lines_d;
   end

   assign o_lines    = lines_q;
   assign o_line_rdy = (lines_q != '0);
`else
   assign o_lines    = '0;
   assign o_line_rdy = 1'b0;
`endif

endmodule
